cn_mod_counter: RTL

- Synchronous modulo-MOD up/down counter whose state bits are CN-semantic storage cells.
- Sits directly downstream of the CN flip-flop primitive: it instantiates CN cells and generates each cell's per-bit c/n command from counter controls.
- Serves as the first register-level consumer of the CN cell, for sequencers and timers in the same design.
- CN cell rule, per bit:
  - n=0: hold.
  - n=1, q=0: q <= c.
  - n=1, q=1: q <= 0.

---
 rtl/cn_mod_counter_pkg.sv | 23 ++
 rtl/cn_mod_counter_if.sv | 29 ++
 rtl/cn_mod_counter_cell.sv | 22 ++
 rtl/cn_mod_counter.sv | 96 +++++++++
 4 files changed

// File: rtl/cn_mod_counter_pkg.sv
// Shared definitions for the CN-cell modulo counter: per-bit command encoding,
// default geometry and the load-difference steering helper.
package cn_mod_counter_pkg;

  typedef struct packed {
    logic n;
    logic c;
  } cn_cmd_t;

  localparam cn_cmd_t CN_HOLD = '{n: 1'b0, c: 1'b0};
  localparam cn_cmd_t CN_SET  = '{n: 1'b1, c: 1'b1};
  localparam cn_cmd_t CN_CLR  = '{n: 1'b1, c: 1'b0};

  localparam int W_DEF   = 4;
  localparam int MOD_DEF = 10;

  // Command that moves one CN bit from cur to tgt in a single edge.
  function automatic cn_cmd_t cn_steer(input logic cur, input logic tgt);
    if (cur == tgt) return CN_HOLD;
    return tgt ? CN_SET : CN_CLR;
  endfunction

endpackage

// File: rtl/cn_mod_counter_if.sv
// Control/status bundle of the CN modulo counter; master drives controls,
// slave (the counter) returns count, complement and flags.
interface cn_mod_counter_if
  import cn_mod_counter_pkg::*;
#(
  parameter int W = W_DEF
);

  logic         en;
  logic         up;
  logic         clr;
  logic         load;
  logic [W-1:0] din;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
  logic         tc;
  logic         wrapped;

  modport master (
    output en, up, clr, load, din,
    input  q, qbar, tc, wrapped
  );

  modport slave (
    input  en, up, clr, load, din,
    output q, qbar, tc, wrapped
  );

endinterface

// File: rtl/cn_mod_counter_cell.sv
// Single CN-semantic storage bit: n=0 holds, n=1 loads c from 0 and
// clears from 1. Synchronous active-high reset pin.
module cn_cell (
  input  logic clk,
  input  logic reset,
  input  logic c,
  input  logic n,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (n) begin
      q <= q ? 1'b0 : c;
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/cn_mod_counter.sv
// Modulo-MOD up/down counter built from W CN cells; every count change is
// expressed as per-bit CN commands generated from the controls and current q.
module cn_mod_counter
  import cn_mod_counter_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int MOD = MOD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  cn_mod_counter_if.slave   bus
);

  localparam logic [W:0]   MOD_EXT = (W+1)'(MOD);
  localparam logic [W-1:0] Q_MAX   = W'(MOD - 1);

  logic [W-1:0] q_bits;
  logic [W-1:0] qbar_bits;
  logic [W-1:0] load_tgt;
  logic [W-1:0] down_tgt;
  logic         at_top;
  logic         at_bot;
  logic         wrap_set;
  logic         wrapped_r;
  cn_cmd_t      cmd [W];

  assign load_tgt = ({1'b0, bus.din} >= MOD_EXT) ? Q_MAX : bus.din;
  assign down_tgt = Q_MAX;

  // Out-of-range counts (only reachable by X-injection) wrap like the top value.
  assign at_top = (q_bits == Q_MAX) || ({1'b0, q_bits} >= MOD_EXT);
  assign at_bot = (q_bits == '0);

  always_comb begin
    logic chain;
    for (int i = 0; i < W; i++) cmd[i] = CN_HOLD;
    wrap_set = 1'b0;
    chain    = 1'b1;
    if (bus.clr) begin
      for (int i = 0; i < W; i++) cmd[i] = CN_CLR;
    end else if (bus.load) begin
      for (int i = 0; i < W; i++) cmd[i] = cn_steer(q_bits[i], load_tgt[i]);
    end else if (bus.en) begin
      if (bus.up) begin
        if (at_top) begin
          for (int i = 0; i < W; i++) cmd[i] = CN_CLR;
          wrap_set = 1'b1;
        end else begin
          for (int i = 0; i < W; i++) begin
            cmd[i] = chain ? CN_SET : CN_HOLD;
            chain  = chain & q_bits[i];
          end
        end
      end else begin
        if (at_bot) begin
          for (int i = 0; i < W; i++) cmd[i] = cn_steer(q_bits[i], down_tgt[i]);
          wrap_set = 1'b1;
        end else begin
          // A bit toggles on decrement when every lower bit is 0 (borrow chain).
          for (int i = 0; i < W; i++) begin
            cmd[i] = chain ? CN_SET : CN_HOLD;
            chain  = chain & ~q_bits[i];
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    cn_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .c     (cmd[gi].c),
      .n     (cmd[gi].n),
      .q     (q_bits[gi]),
      .qbar  (qbar_bits[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrapped_r <= 1'b0;
    end else if (bus.clr) begin
      wrapped_r <= 1'b0;
    end else if (wrap_set) begin
      wrapped_r <= 1'b1;
    end
  end

  assign bus.q       = q_bits;
  assign bus.qbar    = qbar_bits;
  assign bus.wrapped = wrapped_r;
  assign bus.tc      = bus.en & ~bus.clr & ~bus.load &
                       (bus.up ? (q_bits == Q_MAX) : (q_bits == '0));

endmodule
